// File: rtl/chaos_lfsr_whitener.sv
// Whitens Q8.8 chaotic samples into OUT_W-bit random words using a Galois LFSR reseeded per sample.
// Optional statistics ports (reseed_count, zero_fix_count) are enabled by defining CLFSR_STATS_EN.
module chaos_lfsr_whitener #(
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] TAPS         = 16'hB400,
  parameter logic [LFSR_W-1:0] LFSR_INIT    = 16'hACE1,
  parameter int                OUT_W        = 8,
  parameter int                RESEED_WORDS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [15:0]      x_in,
  input  logic             x_valid,
  output logic             x_ready,
  output logic [OUT_W-1:0] rnd_out,
  output logic             rnd_valid,
  input  logic             rnd_ready,
`ifdef CLFSR_STATS_EN
  output logic [15:0]      reseed_count,
  output logic [7:0]       zero_fix_count,
`endif
  output logic             busy
);

  localparam int BCW = 5;
  localparam int WCW = (RESEED_WORDS < 2) ? 1 : $clog2(RESEED_WORDS + 1);

  typedef enum logic [1:0] {IDLE, SEED, RUN, HOLD} state_t;

  state_t             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [7:0]         samp_q;
  logic [BCW-1:0]     bit_cnt_q;
  logic [WCW-1:0]     word_cnt_q;
  logic [OUT_W-1:0]   rnd_out_q;
  logic               rnd_valid_q;

  logic [LFSR_W-1:0]  mix;
  logic               new_bit;
  logic [OUT_W-1:0]   rnd_shift;
  logic               seed_fire, shift_en, word_fire, last_bit, last_word;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return l[0] ? ((l >> 1) ^ TAPS) : (l >> 1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Sample byte-swap spreads the chaotic fraction into the LFSR's high half
  assign mix       = lfsr_q ^ {x_in[7:0], x_in[15:8]};
  assign new_bit   = lfsr_q[0] ^ samp_q[bit_cnt_q[2:0]];
  assign last_bit  = (bit_cnt_q == BCW'(OUT_W - 1));
  assign last_word = (word_cnt_q == WCW'(RESEED_WORDS - 1));

  // stop gates x_ready so an aborted SEED never appears to accept a sample
  assign x_ready   = (state_q == SEED) && !stop;
  assign seed_fire = x_ready && x_valid;
  assign shift_en  = (state_q == RUN) && !stop;
  assign word_fire = (state_q == HOLD) && rnd_ready;

  generate
    if (OUT_W == 1) begin : g_shift1
      assign rnd_shift = new_bit;
    end else begin : g_shiftn
      assign rnd_shift = {rnd_out_q[OUT_W-2:0], new_bit};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start)     state_d = SEED;
      SEED: if (x_valid)   state_d = RUN;
      RUN:  if (last_bit)  state_d = HOLD;
      HOLD: if (rnd_ready) state_d = last_word ? SEED : RUN;
      default:             state_d = IDLE;
    endcase
    if (stop) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q      <= LFSR_INIT;
      samp_q      <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      rnd_out_q   <= '0;
      rnd_valid_q <= 1'b0;
    end else begin
      if (seed_fire) begin
        lfsr_q     <= (mix == '0) ? LFSR_W'(1) : mix;
        samp_q     <= x_in[7:0];
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
      end
      if (shift_en) begin
        lfsr_q    <= lfsr_step(lfsr_q);
        rnd_out_q <= rnd_shift;
        bit_cnt_q <= bit_cnt_q + BCW'(1);
      end
      if (word_fire) begin
        word_cnt_q <= word_cnt_q + WCW'(1);
        bit_cnt_q  <= '0;
      end
      if (stop)                      rnd_valid_q <= 1'b0;
      else if (shift_en && last_bit) rnd_valid_q <= 1'b1;
      else if (word_fire)            rnd_valid_q <= 1'b0;
    end
  end

`ifdef CLFSR_STATS_EN
  logic [15:0] reseed_cnt_q;
  logic [7:0]  zero_fix_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reseed_cnt_q <= '0;
      zero_fix_q   <= '0;
    end else if (seed_fire) begin
      reseed_cnt_q <= sat_inc16(reseed_cnt_q);
      if (mix == '0) zero_fix_q <= sat_inc8(zero_fix_q);
    end
  end

  assign reseed_count   = reseed_cnt_q;
  assign zero_fix_count = zero_fix_q;
`endif

  assign rnd_out   = rnd_out_q;
  assign rnd_valid = rnd_valid_q;
  assign busy      = (state_q != IDLE);

endmodule
